// File: rtl/regfile_mp_pkg.sv
// Shared core constants for the register file, decode and writeback: default widths and address helpers.
package regfile_mp_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;

    // Address width for a register count; never below one bit.
    function automatic int aw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A register is architecturally writable / trackable when it is non-zero and in range.
    function automatic logic addr_ok(input int a, input int n);
        return (a != 0) && (a < n);
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// NWR-way highest-index-wins write resolution: bypass hit/data for one query address plus per-port winner mask.
// Purely combinational, zero latency; no backpressure.
module regfile_wsel
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = aw_of(NREG)
) (
    input  logic [AW-1:0]       addr,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    output logic                hit,
    output logic [XLEN-1:0]     data,
    output logic [NWR-1:0]      win
);

    logic [NWR-1:0] wvalid;

    always_comb begin
        wvalid = '0;
        for (int i = 0; i < NWR; i++) begin
            wvalid[i] = wen[i] && addr_ok(int'(waddr[i*AW +: AW]), NREG);
        end
    end

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        win  = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wvalid[i] && (waddr[i*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wdata[i*XLEN +: XLEN];
            end
            win[i] = wvalid[i];
            for (int j = i + 1; j < NWR; j++) begin
                if (wvalid[j] && (waddr[j*AW +: AW] == waddr[i*AW +: AW])) begin
                    win[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, write-through bypass and a pending-write scoreboard.
// Reads/busy are combinational (zero latency); writes and scoreboard update on the next edge; no backpressure.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_nxt;
    logic [NWR-1:0]  wr_win;
    logic            unused_st_hit;
    logic [XLEN-1:0] unused_st_data;

    regfile_wsel #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_wsel_store (
        .addr  ('0),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .hit   (unused_st_hit),
        .data  (unused_st_data),
        .win   (wr_win)
    );

    // Issue is applied after the write clear so a same-cycle new producer keeps the bit set.
    always_comb begin
        pend_nxt = pending;
        for (int i = 0; i < NWR; i++) begin
            if (wr_win[i]) begin
                pend_nxt[waddr[i*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && addr_ok(int'(iss_rd), NREG)) begin
            pend_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            pend_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_win[i]) begin
                    mem[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
                end
            end
            pending <= pend_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic [NWR-1:0]  unused_win;
        logic            ra_ok;

        assign ra    = raddr[p*AW +: AW];
        assign ra_ok = addr_ok(int'(ra), NREG);

        regfile_wsel #(
            .XLEN (XLEN),
            .NREG (NREG),
            .NWR  (NWR),
            .AW   (AW)
        ) u_wsel_rd (
            .addr  (ra),
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .hit   (byp_hit),
            .data  (byp_data),
            .win   (unused_win)
        );

        // Writes are ignored while reset is held, so the bypass path is gated too.
        always_comb begin
            rdata[p*XLEN +: XLEN] = '0;
            rbusy[p]              = 1'b0;
            if (rst_n && ra_ok) begin
                rdata[p*XLEN +: XLEN] = byp_hit ? byp_data : mem[ra];
                rbusy[p]              = pending[ra] && !byp_hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters (64-bit, 32 regs, 2R/2W).
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [9:0]   raddr;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic         iss_en;
    logic [4:0]   iss_rd;
    logic         flush;

    logic [63:0] rd0, rd1;
    assign rd0 = rdata[63:0];
    assign rd1 = rdata[127:64];

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata),
        .rbusy  (rbusy),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .flush  (flush)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen    = 2'b00;
        waddr  = '0;
        wdata  = '0;
        iss_en = 1'b0;
        iss_rd = '0;
        flush  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        raddr = '0;
        step();
        // Writes and issues during reset must be invisible.
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'd0, 64'hAAAA}; raddr = {5'd0, 5'd5};
        iss_en = 1'b1; iss_rd = 5'd5;
        #1;
        checks++;
        if (rd0 !== 64'd0 || rbusy !== 2'b00) begin
            errors++;
            $display("FAIL reset_bypass rd0=%h rbusy=%b exp 0/00", rd0, rbusy);
        end
        step();
        idle_inputs();
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            raddr = {5'(31 - r), 5'(r)};
            #1;
            checks++;
            if (rd0 !== 64'd0 || rd1 !== 64'd0 || rbusy !== 2'b00) begin
                errors++;
                $display("FAIL reset_read r=%0d rd0=%h rd1=%h rbusy=%b exp 0/0/00", r, rd0, rd1, rbusy);
            end
        end
    endtask

    task automatic test_bypass();
        step();
        wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'd0, 64'hDEAD_BEEF}; raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd0 !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle got=%h exp=%h", rd0, 64'hDEAD_BEEF);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_stored got=%h exp=%h", rd0, 64'hDEAD_BEEF);
        end
    endtask

    task automatic test_priority();
        wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'h22, 64'h11}; raddr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd0 !== 64'h22 || rd1 !== 64'h22) begin
            errors++;
            $display("FAIL prio_bypass rd0=%h rd1=%h exp=22", rd0, rd1);
        end
        step();
        wen = 2'b10; waddr = {5'd0, 5'd0}; wdata = {64'hFF, 64'd0}; raddr = {5'd7, 5'd0};
        #1;
        checks++;
        if (rd1 !== 64'h22 || rd0 !== 64'd0) begin
            errors++;
            $display("FAIL prio_stored_x0_bypass rd1=%h rd0=%h exp 22/0", rd1, rd0);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 64'd0 || rbusy !== 2'b00) begin
            errors++;
            $display("FAIL x0_after_write rd0=%h rbusy=%b exp 0/00", rd0, rbusy);
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_rd = 5'd3; raddr = {5'd3, 5'd3};
        #1;
        checks++;
        if (rbusy !== 2'b00) begin
            errors++;
            $display("FAIL busy_before_edge got=%b exp=00", rbusy);
        end
        step();
        iss_en = 1'b0;
        #1;
        checks++;
        if (rbusy !== 2'b11) begin
            errors++;
            $display("FAIL busy_after_issue got=%b exp=11", rbusy);
        end
        step();
        wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {64'd0, 64'h33};
        #1;
        checks++;
        if (rbusy !== 2'b00 || rd1 !== 64'h33) begin
            errors++;
            $display("FAIL busy_write_comb rbusy=%b rd1=%h exp 00/33", rbusy, rd1);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (rbusy !== 2'b00 || rd0 !== 64'h33) begin
            errors++;
            $display("FAIL busy_write_edge rbusy=%b rd0=%h exp 00/33", rbusy, rd0);
        end
        // Issue to x0 never marks busy.
        iss_en = 1'b1; iss_rd = 5'd0; raddr = {5'd0, 5'd0};
        step();
        idle_inputs();
        #1;
        checks++;
        if (rbusy !== 2'b00) begin
            errors++;
            $display("FAIL busy_x0 got=%b exp=00", rbusy);
        end
    endtask

    task automatic test_issue_write_flush();
        iss_en = 1'b1; iss_rd = 5'd9;
        wen = 2'b10; waddr = {5'd9, 5'd0}; wdata = {64'h99, 64'd0}; raddr = {5'd1, 5'd9};
        step();
        idle_inputs();
        #1;
        checks++;
        if (rbusy[0] !== 1'b1 || rd0 !== 64'h99) begin
            errors++;
            $display("FAIL issue_write_same rbusy0=%b rd0=%h exp 1/99", rbusy[0], rd0);
        end
        checks++;
        if (rbusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL issue_other_reg rbusy1=%b exp=0", rbusy[1]);
        end
        iss_en = 1'b1; iss_rd = 5'd9; flush = 1'b1;
        step();
        idle_inputs();
        #1;
        checks++;
        if (rbusy !== 2'b00) begin
            errors++;
            $display("FAIL flush_over_issue got=%b exp=00", rbusy);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            wen = (k % 2 == 0) ? 2'b01 : 2'b10;
            waddr = {5'd10, 5'd10};
            wdata = {64'h100 + 64'(k), 64'h200 + 64'(k)};
            raddr = {5'd10, 5'd5};
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (rd1 !== 64'h103 || rd0 !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL back_to_back rd1=%h rd0=%h exp 103/deadbeef", rd1, rd0);
        end
    endtask

    task automatic test_async_reset();
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {64'd0, 64'h1234};
        iss_en = 1'b1; iss_rd = 5'd4; raddr = {5'd7, 5'd4};
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 64'h1234 || rbusy[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_preload rd0=%h rbusy0=%b exp 1234/1", rd0, rbusy[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd0 !== 64'd0 || rbusy !== 2'b00 || rd1 !== 64'd0) begin
            errors++;
            $display("FAIL async_reset rd0=%h rd1=%h rbusy=%b exp 0/0/00", rd0, rd1, rbusy);
        end
        #1;
        rst_n = 1'b1;
        wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {64'd0, 64'h55};
        step();
        idle_inputs();
        #1;
        checks++;
        if (rd0 !== 64'h55 || rd1 !== 64'd0) begin
            errors++;
            $display("FAIL post_reset_write rd0=%h rd1=%h exp 55/0", rd0, rd1);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_issue_write_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
